// File: rtl/collision_resolver_if.sv
// Frame-level event bus between the game logic and collision_resolver.
// The bonus signal exists only when EXTRA_LIFE_EN is defined.
interface collision_resolver_if #(
   parameter int LIVES_W = 4
);
   logic               frame_tick;
   logic               collision;
   logic               restart;
`ifdef EXTRA_LIFE_EN
   logic               bonus;
`endif
   logic               hit;
   logic [LIVES_W-1:0] lives;
   logic               invuln;
   logic               blink;
   logic               game_over;

   modport master (
`ifdef EXTRA_LIFE_EN
      output bonus,
`endif
      output frame_tick, collision, restart,
      input  hit, lives, invuln, blink, game_over
   );

   modport slave (
`ifdef EXTRA_LIFE_EN
      input  bonus,
`endif
      input  frame_tick, collision, restart,
      output hit, lives, invuln, blink, game_over
   );
endinterface

// File: rtl/collision_resolver.sv
// Turns per-frame player/hazard overlap into hit events, lives, invulnerability and game over.
// Optional feature macro: EXTRA_LIFE_EN (adds the bonus input and the LIVES_MAX parameter).
module collision_resolver #(
   parameter int LIVES_INIT    = 3,
   parameter int LIVES_W       = 4,
   parameter int INVULN_FRAMES = 60,
   parameter int CNT_W         = 8,
   parameter int BLINK_BIT     = 2
`ifdef EXTRA_LIFE_EN
   ,
   parameter int LIVES_MAX     = 9
`endif
) (
   input  logic                 clk,
   input  logic                 reset_n,
   collision_resolver_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_ALIVE  = 2'd0,
      ST_INVULN = 2'd1,
      ST_DEAD   = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [LIVES_W-1:0] lives_q, lives_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               hit_q, hit_d;
   logic               invuln_q, blink_q, game_over_q;

`ifdef EXTRA_LIFE_EN
   logic [LIVES_W-1:0] lives_inc;

   assign lives_inc = (lives_q >= LIVES_W'(LIVES_MAX)) ? lives_q : lives_q + LIVES_W'(1);
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_ALIVE;
         lives_q     <= LIVES_W'(LIVES_INIT);
         cnt_q       <= '0;
         hit_q       <= 1'b0;
         invuln_q    <= 1'b0;
         blink_q     <= 1'b0;
         game_over_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         lives_q     <= lives_d;
         cnt_q       <= cnt_d;
         hit_q       <= hit_d;
         invuln_q    <= (state_d == ST_INVULN);
         blink_q     <= (state_d == ST_INVULN) && cnt_d[BLINK_BIT];
         game_over_q <= (state_d == ST_DEAD);
      end
   end

   // Restart outranks everything, so no hit or bonus can leak into a fresh game.
   always_comb begin
      state_d = state_q;
      lives_d = lives_q;
      cnt_d   = cnt_q;
      hit_d   = 1'b0;

      if (bus.restart) begin
         state_d = ST_ALIVE;
         lives_d = LIVES_W'(LIVES_INIT);
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_ALIVE: begin
               if (bus.frame_tick && bus.collision) begin
                  hit_d = 1'b1;
                  if (lives_q <= LIVES_W'(1)) begin
                     lives_d = '0;
                     state_d = ST_DEAD;
                  end else begin
`ifdef EXTRA_LIFE_EN
                     lives_d = bus.bonus ? lives_q : lives_q - LIVES_W'(1);
`else
                     lives_d = lives_q - LIVES_W'(1);
`endif
                     state_d = ST_INVULN;
                     cnt_d   = CNT_W'(INVULN_FRAMES - 1);
                  end
               end
`ifdef EXTRA_LIFE_EN
               else if (bus.bonus) begin
                  lives_d = lives_inc;
               end
`endif
            end

            // Collisions are ignored; the window lasts INVULN_FRAMES ticks in total.
            ST_INVULN: begin
               if (bus.frame_tick) begin
                  if (cnt_q == '0) begin
                     state_d = ST_ALIVE;
                  end else begin
                     cnt_d = cnt_q - CNT_W'(1);
                  end
               end
`ifdef EXTRA_LIFE_EN
               if (bus.bonus) begin
                  lives_d = lives_inc;
               end
`endif
            end

            ST_DEAD: begin
               state_d = ST_DEAD;
            end

            default: begin
               state_d = ST_ALIVE;
            end
         endcase
      end
   end

   assign bus.hit       = hit_q;
   assign bus.lives     = lives_q;
   assign bus.invuln    = invuln_q;
   assign bus.blink     = blink_q;
   assign bus.game_over = game_over_q;

endmodule

// File: tb/tb_collision_resolver.sv
// Directed, table-driven bench for collision_resolver (INVULN_FRAMES=4, BLINK_BIT=1, LIVES_INIT=3).
// Bonus sequences are compiled in only when EXTRA_LIFE_EN is defined.
module tb_collision_resolver;

   logic clk;
   logic reset_n;

   collision_resolver_if #(.LIVES_W(4)) bus ();

   collision_resolver #(
      .LIVES_INIT    (3),
      .LIVES_W       (4),
      .INVULN_FRAMES (4),
      .CNT_W         (8),
      .BLINK_BIT     (1)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   typedef struct {
      logic       tick;
      logic       col;
      logic       rst;
      logic       ehit;
      logic [3:0] elives;
      logic       einv;
      logic       eblink;
      logic       ego;
   } vec_t;

   vec_t vecs [20];
   int   total;
   int   fails;
   logic hit_seen;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input int t, input int c, input int r, input int h,
                               input int l, input int i, input int b, input int g);
      vec_t v;
      v.tick   = 1'(t);
      v.col    = 1'(c);
      v.rst    = 1'(r);
      v.ehit   = 1'(h);
      v.elives = 4'(l);
      v.einv   = 1'(i);
      v.eblink = 1'(b);
      v.ego    = 1'(g);
      return v;
   endfunction

   // Inputs are held for exactly one rising edge, then dropped.
   task automatic applyStimulus(input logic t, input logic c, input logic r);
      @(negedge clk);
      bus.frame_tick = t;
      bus.collision  = c;
      bus.restart    = r;
      @(posedge clk);
      #1;
      bus.frame_tick = 1'b0;
      bus.collision  = 1'b0;
      bus.restart    = 1'b0;
   endtask

`ifdef EXTRA_LIFE_EN
   task automatic applyBonus(input logic t, input logic c);
      @(negedge clk);
      bus.frame_tick = t;
      bus.collision  = c;
      bus.bonus      = 1'b1;
      @(posedge clk);
      #1;
      bus.frame_tick = 1'b0;
      bus.collision  = 1'b0;
      bus.bonus      = 1'b0;
   endtask
`endif

   task automatic checkOutput(input string name, input logic eh, input logic [3:0] el,
                              input logic ei, input logic eb, input logic eg);
      total++;
      if (bus.hit !== eh || bus.lives !== el || bus.invuln !== ei ||
          bus.blink !== eb || bus.game_over !== eg) begin
         fails++;
         $display("[TB] FAIL %s: got hit=%0b lives=%0d invuln=%0b blink=%0b game_over=%0b, want hit=%0b lives=%0d invuln=%0b blink=%0b game_over=%0b",
                  name, bus.hit, bus.lives, bus.invuln, bus.blink, bus.game_over,
                  eh, el, ei, eb, eg);
      end
   endtask

   initial begin
      total          = 0;
      fails          = 0;
      reset_n        = 1'b0;
      bus.frame_tick = 1'b0;
      bus.collision  = 1'b0;
      bus.restart    = 1'b0;
`ifdef EXTRA_LIFE_EN
      bus.bonus      = 1'b0;
`endif

      //              tick col rst  hit lives inv blink go
      vecs[0]  = mk(0, 0, 0,   0, 3, 0, 0, 0);
      vecs[1]  = mk(0, 1, 0,   0, 3, 0, 0, 0);
      vecs[2]  = mk(1, 1, 0,   1, 2, 1, 1, 0);
      vecs[3]  = mk(0, 1, 0,   0, 2, 1, 1, 0);
      vecs[4]  = mk(1, 1, 0,   0, 2, 1, 1, 0);
      vecs[5]  = mk(1, 1, 0,   0, 2, 1, 0, 0);
      vecs[6]  = mk(1, 1, 0,   0, 2, 1, 0, 0);
      vecs[7]  = mk(1, 1, 0,   0, 2, 0, 0, 0);
      vecs[8]  = mk(1, 1, 0,   1, 1, 1, 1, 0);
      vecs[9]  = mk(1, 0, 0,   0, 1, 1, 1, 0);
      vecs[10] = mk(1, 0, 0,   0, 1, 1, 0, 0);
      vecs[11] = mk(1, 0, 0,   0, 1, 1, 0, 0);
      vecs[12] = mk(1, 0, 0,   0, 1, 0, 0, 0);
      vecs[13] = mk(1, 0, 0,   0, 1, 0, 0, 0);
      vecs[14] = mk(1, 1, 0,   1, 0, 0, 0, 1);
      vecs[15] = mk(1, 1, 0,   0, 0, 0, 0, 1);
      vecs[16] = mk(0, 0, 1,   0, 3, 0, 0, 0);
      vecs[17] = mk(1, 1, 1,   0, 3, 0, 0, 0);
      vecs[18] = mk(1, 1, 0,   1, 2, 1, 1, 0);
      vecs[19] = mk(1, 1, 1,   0, 3, 0, 0, 0);

      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset", 1'b0, 4'd3, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < 20; i++) begin
         applyStimulus(vecs[i].tick, vecs[i].col, vecs[i].rst);
         checkOutput($sformatf("vec%0d", i), vecs[i].ehit, vecs[i].elives,
                     vecs[i].einv, vecs[i].eblink, vecs[i].ego);
      end

      // Overlap without any frame_tick must never register a hit.
      hit_seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0);
         if (bus.hit === 1'b1) hit_seen = 1'b1;
      end
      total++;
      if (hit_seen !== 1'b0) begin
         fails++;
         $display("[TB] FAIL no_tick_hit: got hit_seen=%0b, want 0", hit_seen);
      end
      checkOutput("no_tick_state", 1'b0, 4'd3, 1'b0, 1'b0, 1'b0);

      // Asynchronous reset in the middle of the invulnerability window.
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("pre_abort", 1'b1, 4'd2, 1'b1, 1'b1, 1'b0);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("async_abort", 1'b0, 4'd3, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("post_abort", 1'b0, 4'd3, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("post_abort_hit", 1'b1, 4'd2, 1'b1, 1'b1, 1'b0);

`ifdef EXTRA_LIFE_EN
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("bonus_restart", 1'b0, 4'd3, 1'b0, 1'b0, 1'b0);
      for (int i = 4; i <= 9; i++) begin
         applyBonus(1'b0, 1'b0);
         checkOutput($sformatf("bonus_to_%0d", i), 1'b0, 4'(i), 1'b0, 1'b0, 1'b0);
      end
      applyBonus(1'b0, 1'b0);
      checkOutput("bonus_saturate", 1'b0, 4'd9, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("bonus_prep_hit", 1'b1, 4'd2, 1'b1, 1'b1, 1'b0);
      repeat (4) applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("bonus_prep_alive", 1'b0, 4'd2, 1'b0, 1'b0, 1'b0);
      applyBonus(1'b1, 1'b1);
      checkOutput("bonus_with_hit", 1'b1, 4'd2, 1'b1, 1'b1, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", total, fails);
      $finish;
   end

endmodule
